// File: rtl/handshake_constant_seq_pkg.sv
// Shared definitions for the registered constant-sequence source.
//   idx_w()   : width of the table index, at least one bit even for DEPTH==1
//   MODE_WRAP : index wraps from DEPTH-1 back to 0
//   MODE_SAT  : index holds at DEPTH-1
package handshake_constant_seq_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/handshake_skid_buf.sv
// Two-entry elastic register. Full throughput with registered ready and
// valid: the main slot drives outs directly, the skid slot catches the one
// token accepted while the consumer stalls.
//   clk, rst              : clock, synchronous active-low reset
//   ins/ins_valid/ins_ready     : upstream channel (ins_ready registered)
//   outs/outs_valid/outs_ready  : downstream channel (outs, outs_valid registered)
module handshake_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  accept;
  logic                  fire;

  assign accept = ins_valid & ins_ready;
  assign fire   = outs_valid & outs_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      outs       <= '0;
      outs_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      ins_ready  <= 1'b0;
    end else begin
      // ins_ready tracks the next skid state, so it always equals !skid_valid
      ins_ready <= 1'b1;
      if (skid_valid) begin
        // ins_ready is low here, so no accept can coincide
        if (fire) begin
          outs       <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          ins_ready  <= 1'b0;
        end
      end else if (accept) begin
        if (!outs_valid || fire) begin
          outs       <= ins;
          outs_valid <= 1'b1;
        end else begin
          skid_data  <= ins;
          skid_valid <= 1'b1;
          ins_ready  <= 1'b0;
        end
      end else if (fire) begin
        // outs keeps its stale value; only the valid flag drops
        outs_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// Elastic constant source: every accepted ctrl token emits the table entry
// selected by an internal index, through a registered skid buffer.
//   clk, rst                 : clock, synchronous active-low reset
//   ctrl_valid/ctrl_ready    : control token channel (ctrl_ready registered)
//   rewind                   : forces the index back to 0 at the edge
//   outs/outs_valid/outs_ready : constant token channel (registered)
//   cur_index                : current table index
module handshake_constant_seq
  import handshake_constant_seq_pkg::*;
#(
  parameter int                          DATA_WIDTH = 32,
  parameter int                          DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] VALUES     = '0,
  parameter int                          MODE       = MODE_WRAP,
  localparam int                         IDX_W      = idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  input  logic                  rewind,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [IDX_W-1:0]      cur_index
);

  localparam int              TBL_N = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] tbl [TBL_N];
  logic                  accept;

  // Table padded to a power of two so the index never selects out of range;
  // unreachable entries are tied to zero.
  for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
    if (i < DEPTH) begin : g_used
      assign tbl[i] = VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign tbl[i] = '0;
    end
  end

  assign accept    = ctrl_valid & ctrl_ready;
  assign cur_index = idx;

  // The accepting token reads the pre-edge index; rewind only affects the next.
  always_ff @(posedge clk) begin
    if (!rst || rewind || DEPTH == 1) begin
      idx <= '0;
    end else if (accept) begin
      if (idx == LAST) idx <= (MODE == MODE_SAT) ? idx : '0;
      else             idx <= idx + 1'b1;
    end
  end

  handshake_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .ins       (tbl[idx]),
    .ins_valid (ctrl_valid),
    .ins_ready (ctrl_ready),
    .outs      (outs),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );

endmodule

// File: tb/tb_handshake_constant_seq.sv
module tb_handshake_constant_seq;

  localparam int DW = 14;
  localparam logic [3*DW-1:0] VALS3 = {14'h1FFF, 14'h0005, 14'h3B2B};
  localparam logic [DW-1:0]   VALS1 = 14'h3B2B;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance 0: DEPTH 3 wrap, 1: DEPTH 3 saturate, 2: DEPTH 1
  logic          cv   [3];
  logic          ordy [3];
  logic          rwd  [3];
  logic          cr   [3];
  logic          ov   [3];
  logic [DW-1:0] o    [3];
  logic [1:0]    ci0, ci1;
  logic          ci2;

  handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(3), .VALUES(VALS3), .MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(cr[0]), .rewind(rwd[0]),
    .outs(o[0]), .outs_valid(ov[0]), .outs_ready(ordy[0]), .cur_index(ci0));
  handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(3), .VALUES(VALS3), .MODE(1)) u_sat (
    .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(cr[1]), .rewind(rwd[1]),
    .outs(o[1]), .outs_valid(ov[1]), .outs_ready(ordy[1]), .cur_index(ci1));
  handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(1), .VALUES(VALS1), .MODE(0)) u_one (
    .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(cr[2]), .rewind(rwd[2]),
    .outs(o[2]), .outs_valid(ov[2]), .outs_ready(ordy[2]), .cur_index(ci2));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  int midx = 0;
  int n_in = 0, n_out = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cur_idx(input int k);
    case (k)
      0:       return ci0;
      1:       return ci1;
      default: return {1'b0, ci2};
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_val(input int k, input int i);
    if (k == 2) return 14'h3B2B;
    case (i)
      0:       return 14'h3B2B;
      1:       return 14'h0005;
      default: return 14'h1FFF;
    endcase
  endfunction

  // One clock: drive inputs at the falling edge, score the accept/fire that
  // the coming rising edge will perform, then check the index afterwards.
  task automatic cycle(input int k, input bit v, input bit r, input bit rw);
    int d;
    d = (k == 2) ? 1 : 3;
    cv[k] = v; ordy[k] = r; rwd[k] = rw;
    #1;
    if (v && cr[k] === 1'b1) begin
      exp_q.push_back(ref_val(k, midx));
      n_in++;
      if (d == 1)             midx = 0;
      else if (midx == d - 1) midx = (k == 1) ? midx : 0;
      else                    midx++;
    end
    if (rw) midx = 0;
    if (ov[k] === 1'b1 && r) begin
      chk("token_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("outs", 32'(o[k]), 32'(exp_q.pop_front()));
      n_out++;
    end
    @(posedge clk); @(negedge clk);
    chk("cur_index", 32'(cur_idx(k)), 32'(midx));
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0 && ov[k] !== 1'b1) break;
      cycle(k, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(ov[k]), 32'd0);
    chk("in_eq_out", 32'(n_in), 32'(n_out));
  endtask

  task automatic do_reset();
    for (int j = 0; j < 3; j++) begin cv[j] = 1'b0; ordy[j] = 1'b0; rwd[j] = 1'b0; end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_q.delete(); midx = 0; n_in = 0; n_out = 0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin cv[j] = 1'b0; ordy[j] = 1'b0; rwd[j] = 1'b0; end
    @(posedge clk); @(negedge clk);
    // reset state
    for (int j = 0; j < 3; j++) begin
      chk("rst_valid", 32'(ov[j]), 32'd0);
      chk("rst_outs", 32'(o[j]), 32'd0);
      chk("rst_ready", 32'(cr[j]), 32'd0);
      chk("rst_index", 32'(cur_idx(j)), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", 32'(cr[0]), 32'd1);

    // streaming at full rate
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1'b1, 1'b1, 1'b0);
      chk("stream_ready", 32'(cr[0]), 32'd1);
      chk("stream_valid", 32'(ov[0]), 32'd1);
    end
    drain(0);

    // backpressure: main + skid fill, then release
    do_reset();
    cycle(0, 1'b1, 1'b0, 1'b0);
    chk("bp_ready1", 32'(cr[0]), 32'd1);
    cycle(0, 1'b1, 1'b0, 1'b0);
    chk("bp_ready_drop", 32'(cr[0]), 32'd0);
    cycle(0, 1'b1, 1'b0, 1'b0);
    chk("bp_hold_outs", 32'(o[0]), 32'h3B2B);
    chk("bp_hold_valid", 32'(ov[0]), 32'd1);
    chk("bp_in", 32'(n_in), 32'd2);
    cycle(0, 1'b1, 1'b1, 1'b0);
    chk("bp_skid_out", 32'(o[0]), 32'h0005);
    chk("bp_ready_back", 32'(cr[0]), 32'd1);
    cycle(0, 1'b1, 1'b1, 1'b0);
    chk("bp_resume", 32'(o[0]), 32'h1FFF);
    drain(0);

    // saturating index
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1'b1, 1'b1, 1'b0);
    chk("sat_index", 32'(ci1), 32'd2);
    drain(1);

    // rewind on the second accept
    do_reset();
    cycle(0, 1'b1, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b1, 1'b1);
    chk("rewind_index", 32'(ci0), 32'd0);
    chk("rewind_tok2", 32'(o[0]), 32'h0005);
    cycle(0, 1'b1, 1'b1, 1'b0);
    chk("rewind_tok3", 32'(o[0]), 32'h3B2B);
    drain(0);

    // reset while both slots are full
    do_reset();
    cycle(0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_q.delete(); midx = 0; n_in = 0; n_out = 0;
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_outs", 32'(o[0]), 32'd0);
    chk("mid_rst_ready", 32'(cr[0]), 32'd0);
    chk("mid_rst_index", 32'(ci0), 32'd0);
    rst = 1'b1;
    cycle(0, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_ready_back", 32'(cr[0]), 32'd1);
    chk("mid_rst_no_out", 32'(ov[0]), 32'd0);
    cycle(0, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_first", 32'(o[0]), 32'h3B2B);
    drain(0);

    // DEPTH 1 under random handshakes
    do_reset();
    for (int i = 0; i < 1000; i++)
      cycle(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
